// File: rtl/guess_judge_4bit.sv
// Number-guess judge: holds the secret target, registers each guess, and turns the
// 4-bit comparator result into sticky HIGH/LOW/HIT flags, a try count and win/lose state.

module compare_4bit (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   output logic       gt_o,
   output logic       eq_o,
   output logic       lt_o
);
   assign gt_o = (a_i > b_i);
   assign eq_o = (a_i == b_i);
   assign lt_o = (a_i < b_i);
endmodule

module guess_judge_4bit #(
   parameter int MAX_TRIES = 7,
   parameter int TRY_W     = 3
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             SET,
   input  logic [3:0]       TARGET,
   input  logic             CLR,
   input  logic             GUESS_VALID,
   input  logic [3:0]       GUESS,
   output logic             READY,
   output logic             HIGH,
   output logic             LOW,
   output logic             HIT,
   output logic             OVER,
   output logic [TRY_W-1:0] TRIES
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_CHECK,
      S_WIN,
      S_LOSE
   } state_t;

   state_t           state_q;
   logic [3:0]       target_q;
   logic [3:0]       guess_q;
   logic [TRY_W-1:0] tries_q;
   logic [TRY_W-1:0] tries_d;
   logic             high_q, low_q, hit_q, over_q;
   logic             cmp_gt, cmp_eq, cmp_lt;

   compare_4bit u_cmp (
      .a_i  (guess_q),
      .b_i  (target_q),
      .gt_o (cmp_gt),
      .eq_o (cmp_eq),
      .lt_o (cmp_lt)
   );

   assign tries_d = tries_q + 1'b1;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         target_q <= '0;
         guess_q  <= '0;
         tries_q  <= '0;
         high_q   <= 1'b0;
         low_q    <= 1'b0;
         hit_q    <= 1'b0;
         over_q   <= 1'b0;
      end else if (CLR) begin
         // target is kept on abort; the next SET overwrites it anyway
         state_q <= S_IDLE;
         tries_q <= '0;
         high_q  <= 1'b0;
         low_q   <= 1'b0;
         hit_q   <= 1'b0;
         over_q  <= 1'b0;
      end else if (SET) begin
         state_q  <= S_ARMED;
         target_q <= TARGET;
         tries_q  <= '0;
         high_q   <= 1'b0;
         low_q    <= 1'b0;
         hit_q    <= 1'b0;
         over_q   <= 1'b0;
      end else begin
         case (state_q)
            S_ARMED: begin
               if (GUESS_VALID) begin
                  guess_q <= GUESS;
                  state_q <= S_CHECK;
               end
            end
            S_CHECK: begin
               high_q  <= cmp_gt;
               low_q   <= cmp_lt;
               hit_q   <= cmp_eq;
               tries_q <= tries_d;
               if (cmp_eq) begin
                  state_q <= S_WIN;
               end else if (tries_d == TRY_W'(MAX_TRIES)) begin
                  state_q <= S_LOSE;
                  over_q  <= 1'b1;
               end else begin
                  state_q <= S_ARMED;
               end
            end
            default: state_q <= state_q;
         endcase
      end
   end

   assign READY = (state_q == S_ARMED);
   assign HIGH  = high_q;
   assign LOW   = low_q;
   assign HIT   = hit_q;
   assign OVER  = over_q;
   assign TRIES = tries_q;
endmodule

// File: doc/guess_judge_4bit.md
Name: guess_judge_4bit

Overview:
- Sequential judge stage wrapped around one Compare_4bit instance in the LaunchPad number-guess flow.
- Registers a 4-bit secret target and each 4-bit guess, and drives them into the comparator (A = guess, B = target).
- Registers the comparator's GT/EQ/LT result into sticky HIGH/LOW/HIT flags.
- Counts attempts and declares win or loss; feeds the LED/FND display logic downstream.

Parameters:
- MAX_TRIES, 7, number of misses allowed before loss; legal range 1 .. 2^TRY_W-1.
- TRY_W, 3, width of the attempt counter and the TRIES port.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- RST  input  1  synchronous, active-high reset.
- SET  input  1  load TARGET and start a new round.
- TARGET  input  4  secret value; sampled only when SET is accepted.
- CLR  input  1  abort the round and return to idle.
- GUESS_VALID  input  1  guess strobe; accepted only when READY=1.
- GUESS  input  4  guess value; sampled with GUESS_VALID.
- READY  output  1  block can accept a guess.
- HIGH  output  1  last guess was greater than target (comparator GT).
- LOW  output  1  last guess was less than target (comparator LT).
- HIT  output  1  last guess equalled target (comparator EQ).
- OVER  output  1  round lost: MAX_TRIES misses used.
- TRIES  output  TRY_W  number of guesses judged in this round.

Behaviour:
- States: IDLE, ARMED, CHECK, WIN, LOSE.
- Reset: RST=1 at a clock edge forces IDLE and clears target_reg, guess_reg, TRIES, HIGH, LOW, HIT and OVER to 0; READY=0. This applies in every state, including mid-CHECK; no flag update occurs on that edge.
- Priority per edge: RST > CLR > SET > GUESS_VALID.
- CLR (any state): go to IDLE and clear flags and TRIES; target_reg is retained but unused.
- SET (any state except under RST/CLR): target_reg <= TARGET; clear TRIES and flags; go to ARMED. If SET and GUESS_VALID are high on the same edge, the guess is dropped.
- IDLE: READY=0; GUESS_VALID is ignored.
- ARMED: READY=1. On GUESS_VALID: guess_reg <= GUESS; go to CHECK.
- CHECK: READY=0; lasts exactly one cycle. The comparator evaluates guess_reg against target_reg combinationally. At the end of this cycle:
  - HIGH<=GT, LOW<=LT, HIT<=EQ; exactly one flag is set.
  - TRIES <= TRIES+1.
  - If EQ: go to WIN.
  - Else if TRIES+1 == MAX_TRIES: go to LOSE, OVER<=1.
  - Else: go to ARMED.
  - GUESS_VALID during CHECK is ignored (not queued).
- Latency: a guess accepted at edge N has flags and TRIES valid after edge N+1. READY is high again after edge N+1 if the round continues, so the maximum throughput is one guess every 2 cycles.
- Flags are sticky until the next CHECK, SET, CLR or RST.
- WIN: HIT=1, READY=0; guesses ignored; hold until SET/CLR.
- LOSE: OVER=1, READY=0; the last miss flag (HIGH or LOW) is held; guesses ignored; hold until SET/CLR.
- TRIES never exceeds MAX_TRIES, so it cannot wrap. A hit on the final permitted try is a WIN with TRIES=MAX_TRIES and OVER=0.
- Boundaries: guess 0 vs target 0 gives HIT; 0 vs 15 gives LOW; 15 vs 0 gives HIGH. The comparison is unsigned.
- All outputs come from registers or from decoding the current state; there are no combinational paths from inputs to outputs.

Test Plan:
- RST, then SET with TARGET=9, then guesses 5, 12, 9 (each strobed when READY=1):
  - After guess 5: LOW=1, TRIES=1.
  - After guess 12: HIGH=1, TRIES=2.
  - After guess 9: HIT=1, TRIES=3, state WIN, READY=0.
  - A further strobe leaves all outputs unchanged.
- MAX_TRIES=7, TARGET=3, seven guesses of 4 -> HIGH=1 each time; after the 7th, OVER=1, TRIES=7, READY=0. An 8th strobe is ignored.
- Boundary pairs:
  - TARGET=15, GUESS=0 -> LOW=1.
  - TARGET=0, GUESS=15 -> HIGH=1.
  - TARGET=0, GUESS=0 -> HIT=1.
  - In each case READY=1 -> 0 -> 1 across the 2-cycle handshake, except after the hit, where READY stays 0 in WIN.
- SET and GUESS_VALID asserted on the same edge while ARMED -> guess dropped, TRIES=0, flags 0, READY=1 on the next cycle with the new target loaded.
- RST asserted during the CHECK cycle of a guess -> next cycle all outputs 0 and state IDLE. A following GUESS_VALID without SET has no effect.
- CLR in LOSE -> IDLE with all outputs 0. A subsequent SET with TARGET=6 and guess 6 -> HIT=1, TRIES=1.
